// File: rtl/ddr_axi_pkg.sv
// Shared types and constants for the DDR controller AXI write-side control.
package ddr_axi_pkg;

  localparam int ID_W    = 2;
  localparam int LEN_W   = 8;
  localparam int NUM_IDS = 1 << ID_W;

  localparam logic [3:0] MAX_TRANSACTIONS = 4'd8;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE,
    DATA
  } wstate_t;

  // Fixed priority: the lowest set index wins.
  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_IDS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = i[ID_W-1:0];
    end
  endfunction

endpackage

// File: rtl/write_fsm_if.sv
// AXI write channels (AW, W, B) between the AXI master and the write control.
interface write_fsm_if;
  import ddr_axi_pkg::*;

  logic             AWVALID;
  logic [ID_W-1:0]  AWID;
  logic [LEN_W-1:0] AWLEN;
  logic             AWREADY;
  logic             WVALID;
  logic             WLAST;
  logic             WREADY;
  logic             BVALID;
  logic [ID_W-1:0]  BID;
  logic [1:0]       BRESP;
  logic             BREADY;

  modport master (
    output AWVALID, AWID, AWLEN, WVALID, WLAST, BREADY,
    input  AWREADY, WREADY, BVALID, BID, BRESP
  );

  modport slave (
    input  AWVALID, AWID, AWLEN, WVALID, WLAST, BREADY,
    output AWREADY, WREADY, BVALID, BID, BRESP
  );

endinterface

// File: rtl/b_resp_arbiter.sv
// Tracks per-ID commit/error bits and issues one B response at a time, lowest ID first.
// Response appears the cycle after a pending bit is visible; held until BREADY.
module b_resp_arbiter
  import ddr_axi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IDS-1:0] wid_done_i,
  input  logic               err_set_i,
  input  logic [ID_W-1:0]    err_id_i,
  input  logic               bready_i,
  output logic               bvalid_o,
  output logic [ID_W-1:0]    bid_o,
  output logic [1:0]         bresp_o
);

  logic [NUM_IDS-1:0] pending_q, pending_d;
  logic [NUM_IDS-1:0] err_q, err_d;
  logic               bvalid_q, bvalid_d;
  logic [ID_W-1:0]    bid_q, bid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic [NUM_IDS-1:0] clr;
  logic [ID_W-1:0]    pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      err_q     <= '0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= BRESP_OKAY;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    clr      = '0;
    pick     = lowest_set(pending_q);

    // Selection only while B is idle, which also forces a gap cycle between responses.
    if (bvalid_q) begin
      if (bready_i) bvalid_d = 1'b0;
    end else if (pending_q != '0) begin
      bvalid_d  = 1'b1;
      bid_d     = pick;
      bresp_d   = err_q[pick] ? BRESP_SLVERR : BRESP_OKAY;
      clr[pick] = 1'b1;
    end

    pending_d = (pending_q & ~clr) | wid_done_i;
    err_d     = err_q & ~clr;
    if (err_set_i) err_d[err_id_i] = 1'b1;
  end

  assign bvalid_o = bvalid_q;
  assign bid_o    = bid_q;
  assign bresp_o  = bresp_q;

endmodule

// File: rtl/write_fsm.sv
// AXI write-side control: accepts one AW burst at a time, counts its W beats, flags
// malformed bursts; AWREADY registered, WREADY follows !wfull combinationally.
module write_fsm
  import ddr_axi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  write_fsm_if.slave         axi,
  input  logic               wfull,
  input  logic [3:0]         num_transactions,
  input  logic [NUM_IDS-1:0] wid_done,
  output logic               load_aw,
  output logic               push_w,
  output logic               scheduler_en
);

  wstate_t          state_q, state_d;
  logic             awready_q, awready_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d;
  logic             wready;
  logic             err_set;
  logic             bvalid;

  assign wready  = (state_q == DATA) && !wfull;
  assign load_aw = axi.AWVALID && awready_q;
  assign push_w  = axi.WVALID && wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      awready_q  <= 1'b0;
      beat_cnt_q <= '0;
      cur_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      awready_q  <= awready_d;
      beat_cnt_q <= beat_cnt_d;
      cur_id_q   <= cur_id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    awready_d  = 1'b0;
    beat_cnt_d = beat_cnt_q;
    cur_id_d   = cur_id_q;
    err_set    = 1'b0;

    case (state_q)
      IDLE: begin
        awready_d = !load_aw && (num_transactions < MAX_TRANSACTIONS);
        if (load_aw) begin
          state_d    = DATA;
          cur_id_d   = axi.AWID;
          beat_cnt_d = axi.AWLEN;
        end
      end
      DATA: begin
        if (push_w) begin
          // Burst closes on WLAST or an exhausted count; disagreement marks the ID bad.
          if (axi.WLAST || (beat_cnt_q == '0)) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            err_set    = axi.WLAST != (beat_cnt_q == '0);
          end else begin
            beat_cnt_d = beat_cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  b_resp_arbiter u_b_resp_arbiter (
    .clk        (clk),
    .rst        (rst),
    .wid_done_i (wid_done),
    .err_set_i  (err_set),
    .err_id_i   (cur_id_q),
    .bready_i   (axi.BREADY),
    .bvalid_o   (bvalid),
    .bid_o      (axi.BID),
    .bresp_o    (axi.BRESP)
  );

  assign axi.AWREADY = awready_q;
  assign axi.WREADY  = wready;
  assign axi.BVALID  = bvalid;

  assign scheduler_en = (num_transactions != 4'd0) && !load_aw && !push_w && !wfull && !bvalid;

endmodule

// File: tb/tb_write_fsm.sv
// Directed cycle-by-cycle vectors plus hand sequences for arbitration hold and mid-burst reset.
module tb_write_fsm;
  import ddr_axi_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wfull;
  logic [3:0] num_transactions;
  logic [3:0] wid_done;
  logic       load_aw, push_w, scheduler_en;

  always #5 clk = ~clk;

  write_fsm_if axi();

  write_fsm dut (
    .clk              (clk),
    .rst              (rst),
    .axi              (axi.slave),
    .wfull            (wfull),
    .num_transactions (num_transactions),
    .wid_done         (wid_done),
    .load_aw          (load_aw),
    .push_w           (push_w),
    .scheduler_en     (scheduler_en)
  );

  // exp = {awready, wready, bvalid, bid[1:0], bresp[1:0], load_aw, push_w, scheduler_en}
  typedef struct {
    logic       rst;
    logic       awvalid;
    logic [1:0] awid;
    logic [7:0] awlen;
    logic       wvalid;
    logic       wlast;
    logic       bready;
    logic       wfull;
    logic [3:0] num;
    logic [3:0] wd;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic awv, input logic [1:0] id, input logic [7:0] len,
                     input logic wv, input logic wl, input logic br, input logic wf,
                     input logic [3:0] num, input logic [3:0] wd, input logic [9:0] exp);
    vec_t t;
    t.rst = r; t.awvalid = awv; t.awid = id; t.awlen = len; t.wvalid = wv; t.wlast = wl;
    t.bready = br; t.wfull = wf; t.num = num; t.wd = wd; t.exp = exp;
    vecs.push_back(t);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {axi.AWREADY, axi.WREADY, axi.BVALID, axi.BID, axi.BRESP, load_aw, push_w, scheduler_en};
  endfunction

  task automatic idle_inputs;
    axi.AWVALID = 0; axi.AWID = 0; axi.AWLEN = 0; axi.WVALID = 0; axi.WLAST = 0;
    axi.BREADY = 0; wfull = 0; wid_done = 0;
  endtask

  initial begin
    bit seen;
    rst = 1; num_transactions = 0;
    idle_inputs();
    repeat (2) @(posedge clk);

    //   rst awv id len wv wl br wf num wd       aw w b id rr l p s
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 10'b0_0_0_00_00_0_0_0);
    // single burst ID1, 4 beats, then commit
    add(0, 1, 1, 3, 0, 0, 0, 0, 0, 4'b0000, 10'b0_0_0_00_00_0_0_0);
    add(0, 1, 1, 3, 0, 0, 0, 0, 0, 4'b0000, 10'b1_0_0_00_00_1_0_0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1, 4'b0000, 10'b0_1_0_00_00_0_1_0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1, 4'b0000, 10'b0_1_0_00_00_0_1_0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1, 4'b0000, 10'b0_1_0_00_00_0_1_0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1, 4'b0000, 10'b0_1_0_00_00_0_1_0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 10'b0_0_0_00_00_0_0_1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 10'b1_0_0_00_00_0_0_0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 10'b1_0_0_00_00_0_0_0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 10'b1_0_1_01_00_0_0_0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 10'b1_0_1_01_00_0_0_0);
    // outstanding limit reached, then released
    add(0, 0, 0, 0, 0, 0, 0, 0, 8, 4'b0000, 10'b1_0_0_01_00_0_0_1);
    add(0, 1, 2, 3, 0, 0, 0, 0, 8, 4'b0000, 10'b0_0_0_01_00_0_0_1);
    add(0, 1, 2, 3, 0, 0, 0, 0, 8, 4'b0000, 10'b0_0_0_01_00_0_0_1);
    add(0, 1, 2, 3, 0, 0, 0, 0, 7, 4'b0000, 10'b0_0_0_01_00_0_0_1);
    add(0, 1, 2, 3, 0, 0, 0, 0, 7, 4'b0000, 10'b1_0_0_01_00_1_0_0);
    // early WLAST on beat 2 of ID2 -> SLVERR
    add(0, 0, 0, 0, 1, 0, 0, 0, 7, 4'b0000, 10'b0_1_0_01_00_0_1_0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 7, 4'b0000, 10'b0_1_0_01_00_0_1_0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 7, 4'b0100, 10'b0_0_0_01_00_0_0_1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 7, 4'b0000, 10'b1_0_0_01_00_0_0_1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 7, 4'b0000, 10'b1_0_1_10_10_0_0_0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 7, 4'b0000, 10'b1_0_0_10_10_0_0_1);
    // wfull stall mid-burst on ID3 (2 beats)
    add(0, 1, 3, 1, 0, 0, 0, 0, 7, 4'b0000, 10'b1_0_0_10_10_1_0_0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 7, 4'b0000, 10'b0_0_0_10_10_0_0_0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 7, 4'b0000, 10'b0_0_0_10_10_0_0_0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 7, 4'b0000, 10'b0_1_0_10_10_0_1_0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 7, 4'b0000, 10'b0_1_0_10_10_0_1_0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 7, 4'b1000, 10'b0_0_0_10_10_0_0_1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 7, 4'b0000, 10'b1_0_0_10_10_0_0_1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 7, 4'b0000, 10'b1_0_1_11_00_0_0_0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 7, 4'b0000, 10'b1_0_0_11_00_0_0_1);

    foreach (vecs[i]) begin
      tick();
      rst = vecs[i].rst; axi.AWVALID = vecs[i].awvalid; axi.AWID = vecs[i].awid;
      axi.AWLEN = vecs[i].awlen; axi.WVALID = vecs[i].wvalid; axi.WLAST = vecs[i].wlast;
      axi.BREADY = vecs[i].bready; wfull = vecs[i].wfull;
      num_transactions = vecs[i].num; wid_done = vecs[i].wd;
      #2;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Two IDs commit together: ID1 first, held under backpressure, then ID3.
    tick(); idle_inputs(); wid_done = 4'b1010;
    tick(); idle_inputs();
    seen = 0;
    for (int n = 0; n < 6 && !seen; n++) begin
      #2;
      if (axi.BVALID) seen = 1; else tick();
    end
    chk("bvalid_dual_seen", 32'(seen), 32'd1);
    chk("bid_first", 32'(axi.BID), 32'd1);
    for (int n = 0; n < 3; n++) begin
      tick(); #2;
      chk($sformatf("bid_hold%0d", n), 32'({axi.BVALID, axi.BID, axi.BRESP}), 32'({1'b1, 2'd1, BRESP_OKAY}));
    end
    tick(); axi.BREADY = 1;
    tick(); axi.BREADY = 0; #2;
    chk("bvalid_gap", 32'(axi.BVALID), 32'd0);
    tick(); #2;
    chk("bid_second", 32'({axi.BVALID, axi.BID, axi.BRESP}), 32'({1'b1, 2'd3, BRESP_OKAY}));
    tick(); axi.BREADY = 1;
    tick(); axi.BREADY = 0;

    // Reset mid-burst with a response showing and another still pending.
    tick(); wid_done = 4'b0011;
    tick(); wid_done = 0; axi.AWVALID = 1; axi.AWID = 0; axi.AWLEN = 3; #2;
    chk("rst_seq_load", 32'(load_aw), 32'd1);
    tick(); axi.AWVALID = 0; axi.WVALID = 1; #2;
    chk("rst_seq_b0", 32'({axi.BVALID, axi.BID, push_w}), 32'({1'b1, 2'd0, 1'b1}));
    tick(); #2;
    chk("rst_seq_beat2", 32'(push_w), 32'd1);
    tick(); rst = 1;
    tick(); rst = 0; axi.BREADY = 1; #2;
    chk("rst_state", 32'({axi.AWREADY, axi.WREADY, axi.BVALID, push_w}), 32'd0);
    for (int n = 0; n < 4; n++) begin
      tick(); #2;
      chk($sformatf("rst_no_pending%0d", n), 32'({axi.BVALID, axi.WREADY}), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
